smc777_mem_arbiter: RTL and testbench

Single-port main-RAM arbiter for the SMC-777 core. It shares the 64 KiB CPU RAM between three requesters: the ioctl download loader, the video fetch path fed by the mc6845 address stream, and the tv80n Z80 CPU. It sits between the three requesters and the RAM macro. The CPU is stalled through `wait_n` whenever it does not own the RAM.

---
 rtl/smc777_pkg.sv | 6 +
 rtl/smc777_slot_timer.sv | 17 +
 rtl/smc777_mem_arbiter.sv | 95 +++++++++
 tb/tb_smc777_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smc777_pkg.sv
// smc777_pkg: shared arbiter state type and main-RAM geometry
package smc777_pkg;
  localparam int SMC777_RAM_AW = 16;
  localparam int SMC777_RAM_DW = 8;
  typedef enum logic [1:0] {IDLE, CPU_RD, VID_RD, DL} arb_state_t;
endpackage

// File: rtl/smc777_slot_timer.sv
// smc777_slot_timer: free-running modulo-SLOTS counter flagging the first and last slot
module smc777_slot_timer #(
  parameter int SLOTS = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic slot0,
  output logic slot_last
);
  localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  logic [SW-1:0] slot;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) slot <= '0;
    else slot <= slot_last ? '0 : slot + 1'b1;
  assign slot0 = slot == '0;
  assign slot_last = slot == SW'(SLOTS - 1);
endmodule

// File: rtl/smc777_mem_arbiter.sv
// smc777_mem_arbiter: single-port main-RAM arbiter (download > video slot 0 > CPU).
// Define SMC777_ARB_STATS_EN to add saturating stall/miss statistics outputs.
module smc777_mem_arbiter
  import smc777_pkg::*;
#(
  parameter int AW = SMC777_RAM_AW,
  parameter int DW = SMC777_RAM_DW,
  parameter int SLOTS = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_wait_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_valid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef SMC777_ARB_STATS_EN
  ,
  output logic [15:0]   stat_cpu_stall,
  output logic [15:0]   stat_vid_miss
`endif
);
  arb_state_t state;
  logic slot0, slot_last, done, idle, dl_grant, vid_grant, cpu_go, wr_grant, rd_grant;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  smc777_slot_timer #(.SLOTS(SLOTS)) u_slot (
    .clk(clk),
    .reset_n(reset_n),
    .slot0(slot0),
    .slot_last(slot_last)
  );

  // Grants are decided combinationally in IDLE so the RAM sees the address in the grant cycle.
  assign idle = reset_n && state == IDLE;
  assign dl_grant = reset_n && ((idle && dl_active) || state == DL);
  assign vid_grant = idle && !dl_active && slot0 && vid_req && !vid_valid;
  assign cpu_go = idle && !dl_active && !vid_grant && cpu_req && !done;
  assign wr_grant = cpu_go && cpu_we;
  // A read started in the last slot would occupy slot 0, which belongs to a waiting video fetch.
  assign rd_grant = cpu_go && !cpu_we && !(slot_last && vid_req);
  assign cpu_wait_n = !reset_n || !cpu_req || done;

  always_comb begin
    mem_addr = dl_grant ? dl_addr : vid_grant ? vid_addr : cpu_go ? cpu_addr : addr_q;
    mem_we = dl_grant ? dl_wr : wr_grant;
    mem_wdata = dl_grant ? dl_data : wr_grant ? cpu_wdata : wdata_q;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cpu_rdata <= '0;
      vid_rdata <= '0;
      vid_valid <= 1'b0;
      done <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      vid_valid <= state == VID_RD;
      done <= wr_grant || state == CPU_RD;
      addr_q <= mem_addr;
      wdata_q <= mem_wdata;
      if (state == CPU_RD) cpu_rdata <= mem_rdata;
      if (state == VID_RD) vid_rdata <= mem_rdata;
      state <= state == IDLE ? (dl_active ? DL : vid_grant ? VID_RD : rd_grant ? CPU_RD : IDLE)
             : (state == DL && dl_active) ? DL : IDLE;
    end

`ifdef SMC777_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stat_cpu_stall <= '0;
      stat_vid_miss <= '0;
    end else begin
      if (cpu_req && !cpu_wait_n && stat_cpu_stall != 16'hFFFF) stat_cpu_stall <= stat_cpu_stall + 1'b1;
      if (slot0 && vid_req && !vid_grant && !vid_valid && stat_vid_miss != 16'hFFFF)
        stat_vid_miss <= stat_vid_miss + 1'b1;
    end
`endif
endmodule

// File: tb/tb_smc777_mem_arbiter.sv
// tb_smc777_mem_arbiter: scoreboard bench with a behavioural RAM image and timing expectations
module tb_smc777_mem_arbiter;
  localparam int SLOTS = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic dl_active = 1'b0, dl_wr = 1'b0;
  logic [15:0] dl_addr = '0;
  logic [7:0] dl_data = '0;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic cpu_wait_n;
  logic vid_req = 1'b0;
  logic [15:0] vid_addr = '0;
  logic [7:0] vid_rdata;
  logic vid_valid;
  logic [15:0] mem_addr;
  logic mem_we;
  logic [7:0] mem_wdata, mem_rdata;
`ifdef SMC777_ARB_STATS_EN
  logic [15:0] stat_cpu_stall, stat_vid_miss;
`endif
  logic [7:0] ram [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] cpu_q[$], vid_q[$];
  logic [7:0] dlb [0:15];
  logic [15:0] rset [0:15];
  int vectors = 0, miscompares = 0, cyc = 0;
  int clat, vlat, dl_end, cpu_ret, vid_ret, s0;

  smc777_mem_arbiter #(.AW(16), .DW(8), .SLOTS(SLOTS)) dut (
    .clk(clk), .reset_n(reset_n),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef SMC777_ARB_STATS_EN
    , .stat_cpu_stall(stat_cpu_stall), .stat_vid_miss(stat_vid_miss)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (reset_n) begin
      if (cpu_req && !cpu_we && cpu_wait_n) begin
        if (cpu_q.size() == 0) check("cpu_unexpected_completion", 1, 0);
        else check("cpu_rdata", int'(cpu_rdata), int'(cpu_q.pop_front()));
      end
      if (vid_valid) begin
        if (vid_q.size() == 0) check("vid_unexpected_valid", 1, 0);
        else check("vid_rdata", int'(vid_rdata), int'(vid_q.pop_front()));
      end
    end

  task automatic wait_slot(input int s);
    do @(negedge clk); while ((cyc + 1) % SLOTS != s);
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d, output int lat);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (we) ref_mem[a] = d;
    else cpu_q.push_back(ref_mem[a]);
    lat = 0;
    forever begin
      @(negedge clk);
      if (cpu_wait_n) break;
      lat++;
      if (lat > 60) begin check("cpu_timeout", lat, 0); lat = -1; break; end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic vid_access(input logic [15:0] a, output int lat);
    @(posedge clk); #1;
    vid_req = 1'b1; vid_addr = a;
    vid_q.push_back(ref_mem[a]);
    lat = 0;
    forever begin
      @(negedge clk);
      if (vid_valid) break;
      lat++;
      if (lat > 60) begin check("vid_timeout", lat, 0); lat = -1; break; end
    end
    @(posedge clk); #1;
    vid_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wait_n", cpu_wait_n, 1);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_vid_rdata", vid_rdata, 0);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // uncontended write in slot 1
    wait_slot(1);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A; ref_mem[16'h1234] = 8'h5A;
    @(negedge clk);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 16'h1234);
    check("wr_mem_wdata", mem_wdata, 8'h5A);
    check("wr_wait_low", cpu_wait_n, 0);
    @(negedge clk);
    check("wr_wait_high", cpu_wait_n, 1);
    check("wr_mem_we_single", mem_we, 0);
    check("wr_addr_hold", mem_addr, 16'h1234);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;

    wait_slot(1);
    cpu_access(1'b0, 16'h1234, 8'h00, clat);
    check("rd_latency", clat, 2);
    check("rd_data", cpu_rdata, 8'h5A);

    // video fetches
    cpu_access(1'b1, 16'h2000, 8'hA5, clat);
    wait_slot(0);
    vid_access(16'h2000, vlat);
    check("vid_latency_slot0", vlat, 2);
    check("vid_data", vid_rdata, 8'hA5);
    wait_slot(1);
    vid_access(16'h2000, vlat);
    check("vid_latency_slot1", vlat, SLOTS + 1);

    // CPU read and video colliding on slot 0
    cpu_access(1'b1, 16'h2100, 8'h3C, clat);
    wait_slot(0);
    fork
      cpu_access(1'b0, 16'h2100, 8'h00, clat);
      vid_access(16'h2000, vlat);
    join
    check("contend_vid_latency", vlat, 2);
    check("contend_cpu_latency", clat, 4);

    // download with concurrent CPU and video requests
    for (int i = 0; i < 16; i++) begin
      dlb[i] = 8'($urandom);
      ref_mem[i] = dlb[i];
    end
    @(posedge clk); #1 dl_active = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(posedge clk); #1;
          dl_wr = 1'b1; dl_addr = 16'(i); dl_data = dlb[i];
          @(posedge clk); #1 dl_wr = 1'b0;
        end
        @(posedge clk); #1 dl_active = 1'b0;
        dl_end = cyc;
      end
      begin cpu_access(1'b0, 16'h0003, 8'h00, clat); cpu_ret = cyc; end
      begin vid_access(16'h0005, vlat); vid_ret = cyc; end
    join
    check("dl_cpu_held", int'(cpu_ret - 1 >= dl_end + 2), 1);
    check("dl_vid_held", int'(vid_ret - 1 >= dl_end + 3), 1);
    for (int i = 0; i < 16; i++) cpu_access(1'b0, 16'(i), 8'h00, clat);

`ifdef SMC777_ARB_STATS_EN
    s0 = int'(stat_cpu_stall);
    wait_slot(1);
    cpu_access(1'b0, 16'h2100, 8'h00, clat);
    check("stat_cpu_stall_delta", int'(stat_cpu_stall) - s0, 2);
`endif

    // randomized traffic over a small written address set
    for (int i = 0; i < 16; i++) begin
      rset[i] = 16'h1000 + 16'(i * 17);
      cpu_access(1'b1, rset[i], 8'($urandom), clat);
      check("rnd_wr_latency", clat, 1);
    end
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: begin
          cpu_access(1'b1, rset[$urandom_range(0, 15)], 8'($urandom), clat);
          check("rnd_wr_latency", clat, 1);
        end
        1: begin
          cpu_access(1'b0, rset[$urandom_range(0, 15)], 8'h00, clat);
          check("rnd_rd_latency", clat, 2);
        end
        default: begin
          fork
            begin repeat ($urandom_range(0, 3)) @(posedge clk); cpu_access(1'b0, rset[$urandom_range(0, 15)], 8'h00, clat); end
            begin repeat ($urandom_range(0, 3)) @(posedge clk); vid_access(rset[$urandom_range(0, 15)], vlat); end
          join
          check("rnd_cpu_worst_stall", int'(clat >= 1 && clat <= SLOTS + 2), 1);
          check("rnd_vid_worst_latency", int'(vlat >= 2 && vlat <= SLOTS + 2), 1);
        end
      endcase
    end

    // reset in the middle of a CPU read
    cpu_access(1'b1, 16'h0040, 8'h77, clat);
    cpu_access(1'b0, 16'h2100, 8'h00, clat);
    wait_slot(1);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    @(posedge clk); #3;
    check("rst_mid_wait_low", cpu_wait_n, 0);
    reset_n = 1'b0;
    #1;
    check("arst_wait_n", cpu_wait_n, 1);
    check("arst_cpu_rdata", cpu_rdata, 0);
    check("arst_vid_rdata", vid_rdata, 0);
    check("arst_vid_valid", vid_valid, 0);
    check("arst_mem_we", mem_we, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("arst_no_late_data", cpu_rdata, 0);
      check("arst_no_vid_pulse", vid_valid, 0);
    end
    check("cpu_queue_drained", cpu_q.size(), 0);
    check("vid_queue_drained", vid_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
